// File: rtl/masked_reduce_pipe.sv
// Pipelined per-bit force/invert stage with AND/OR/XOR reductions on a valid/ready stream.
// Optional saturating hit counter when MRP_HIT_COUNT_EN is defined.
module masked_reduce_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_force_en,
  input  logic [WIDTH-1:0] cfg_force_val,
  input  logic [WIDTH-1:0] cfg_invert,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_and,
  output logic             out_or,
  output logic             out_xor
`ifdef MRP_HIT_COUNT_EN
  ,
  output logic [CNT_W-1:0] hit_count
`endif
);

  if (WIDTH < 1) begin : g_bad_width
    $error("WIDTH must be >= 1");
  end
  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("STAGES must be 1..8");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("CNT_W must be >= 1");
  end

  // Async assert, clock-synchronous release of the internal reset
  logic [1:0] rst_sync_q;
  logic       rst_ni;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_ni = rst_sync_q[1];

  logic [WIDTH-1:0] fen_q;
  logic [WIDTH-1:0] fval_q;
  logic [WIDTH-1:0] inv_q;
  logic [WIDTH-1:0] xf;

  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0][WIDTH-1:0] d_q;
  logic [STAGES-1:0][2:0]       r_q;
  logic [STAGES-1:0]            adv;

  always_comb begin
    xf = ((in_data & ~fen_q) | (fval_q & fen_q)) ^ inv_q;
  end

  // A stage may load when it is empty or its successor is draining it
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !v_q[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !v_q[k] | adv[k+1];
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      fen_q  <= '0;
      fval_q <= '0;
      inv_q  <= '0;
    end else if (cfg_we) begin
      fen_q  <= cfg_force_en;
      fval_q <= cfg_force_val;
      inv_q  <= cfg_invert;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= '0;
      d_q <= '0;
      r_q <= '0;
    end else begin
      if (adv[0]) begin
        v_q[0] <= in_valid;
        if (in_valid) begin
          d_q[0] <= xf;
          r_q[0] <= {&xf, |xf, ^xf};
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) begin
            d_q[k] <= d_q[k-1];
            r_q[k] <= r_q[k-1];
          end
        end
      end
    end
  end

  assign in_ready  = rst_ni & adv[0];
  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];
  assign out_and   = r_q[STAGES-1][2];
  assign out_or    = r_q[STAGES-1][1];
  assign out_xor   = r_q[STAGES-1][0];

`ifdef MRP_HIT_COUNT_EN
  logic [CNT_W-1:0] hit_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_q <= '0;
    end else if (out_valid && out_ready && out_and && !(&hit_q)) begin
      hit_q <= hit_q + 1'b1;
    end
  end

  assign hit_count = hit_q;
`endif

endmodule

// File: tb/tb_masked_reduce_pipe.sv
// Scoreboard bench for masked_reduce_pipe: random and directed beats vs a mask model.
// Define MRP_HIT_COUNT_EN to also check the saturating hit counter.
module tb_masked_reduce_pipe;
  localparam int W  = 4;
  localparam int S  = 2;
  localparam int CW = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we;
  logic [W-1:0] cfg_force_en;
  logic [W-1:0] cfg_force_val;
  logic [W-1:0] cfg_invert;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_and;
  logic         out_or;
  logic         out_xor;
`ifdef MRP_HIT_COUNT_EN
  logic [CW-1:0] hit_count;
`endif

  masked_reduce_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_force_en (cfg_force_en),
    .cfg_force_val(cfg_force_val),
    .cfg_invert   (cfg_invert),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_and      (out_and),
    .out_or       (out_or),
    .out_xor      (out_xor)
`ifdef MRP_HIT_COUNT_EN
    ,
    .hit_count    (hit_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         a;
    logic         o;
    logic         x;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] m_fen;
  logic [W-1:0] m_fval;
  logic [W-1:0] m_inv;
  int           checks = 0;
  int           errors = 0;
  int           since_rst = 0;
  bit           hold_prev = 0;
  logic [W-1:0] hold_d;
  bit           saw_stall = 0;
  int unsigned  m_hc = 0;

  function automatic exp_t model(input logic [W-1:0] din);
    exp_t e;
    int   ones;
    ones = 0;
    for (int i = 0; i < W; i++) begin
      e.d[i] = (m_fen[i] ? m_fval[i] : din[i]) ^ m_inv[i];
      if (e.d[i]) ones++;
    end
    e.a = (ones == W);
    e.o = (ones != 0);
    e.x = (ones % 2 == 1);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_fen = '0;
      m_fval = '0;
      m_inv = '0;
      m_hc = 0;
      hold_prev = 0;
      since_rst = 0;
    end else begin
      since_rst++;
      if (hold_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(hold_d));
      end
      if (since_rst > 3) begin
        check("in_ready", 32'(in_ready),
              32'(!(q.size() >= S && !out_ready)));
        if (!in_ready) saw_stall = 1;
      end
`ifdef MRP_HIT_COUNT_EN
      check("hit_count", 32'(hit_count), m_hc);
`endif
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out actual=%0h required=none", out_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("out_data", 32'(out_data), 32'(e.d));
          check("out_and", 32'(out_and), 32'(e.a));
          check("out_or", 32'(out_or), 32'(e.o));
          check("out_xor", 32'(out_xor), 32'(e.x));
          if (e.a && m_hc < (2 ** CW) - 1) m_hc++;
        end
      end
      hold_prev = out_valid && !out_ready;
      hold_d = out_data;
      if (in_valid && in_ready) q.push_back(model(in_data));
      if (cfg_we) begin
        m_fen = cfg_force_en;
        m_fval = cfg_force_val;
        m_inv = cfg_invert;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_wait(input logic [W-1:0] d, input logic [W-1:0] ed,
                           input logic ea, input logic eo, input logic ex);
    int lat;
    bit ok;
    in_valid = 1'b1;
    in_data = d;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    check("accept_timeout", 32'(ok), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, S);
    check("d_data", 32'(out_data), 32'(ed));
    check("d_and", 32'(out_and), 32'(ea));
    check("d_or", 32'(out_or), 32'(eo));
    check("d_xor", 32'(out_xor), 32'(ex));
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int n;
    rst_n = 1'b0;
    cfg_we = 1'b0;
    cfg_force_en = '0;
    cfg_force_val = '0;
    cfg_invert = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    do_reset();

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_reds", 32'({out_and, out_or, out_xor}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    send_wait(4'b1010, 4'b1010, 1'b0, 1'b1, 1'b0);

    cfg_we = 1'b1;
    cfg_force_en = 4'b1100;
    cfg_force_val = 4'b1000;
    cfg_invert = 4'b0101;
    tick();
    cfg_we = 1'b0;
    send_wait(4'b1010, 4'b1111, 1'b1, 1'b1, 1'b0);
    send_wait(4'b0011, 4'b1110, 1'b0, 1'b1, 1'b1);

    // cfg in the same cycle as beat A; B follows with the new masks
    in_valid = 1'b1;
    in_data = 4'b1010;
    cfg_we = 1'b1;
    cfg_force_en = 4'b0000;
    cfg_force_val = 4'b0000;
    cfg_invert = 4'b1111;
    tick();
    cfg_we = 1'b0;
    in_data = 4'b1010;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("cfgA_data", 32'(out_data), 32'b1111);
    tick();
    check("cfgB_valid", 32'(out_valid), 32'd1);
    check("cfgB_data", 32'(out_data), 32'b0101);
    tick();

    // back-to-back stream with a mid-stream consumer stall
    saw_stall = 0;
    sent = 0;
    for (int c = 0; c < 60 && sent < 8; c++) begin
      out_ready = !(c >= 3 && c < 8);
      in_valid = 1'b1;
      if (c == 0) in_data = 4'($urandom);
      @(negedge clk);
      if (in_ready) begin
        sent++;
        tick();
        in_data = 4'($urandom);
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_sent", sent, 8);
    check("stall_seen", 32'(saw_stall), 32'd1);
    drain();

    // reset with two beats in flight
    in_valid = 1'b1;
    in_data = 4'b0001;
    tick();
    in_data = 4'b0010;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    send_wait(4'b0110, 4'b0110, 1'b0, 1'b1, 1'b0);

`ifdef MRP_HIT_COUNT_EN
    cfg_we = 1'b1;
    cfg_force_en = 4'b1111;
    cfg_force_val = 4'b1111;
    cfg_invert = 4'b0000;
    tick();
    cfg_we = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_wait(4'($urandom), 4'b1111, 1'b1, 1'b1, 1'b0);
      check("hit_seq", 32'(hit_count), (i < 3) ? i : 3);
    end
`endif

    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom % 4) != 0;
      in_data = 4'($urandom);
      out_ready = ($urandom % 4) != 0;
      cfg_we = ($urandom % 16) == 0;
      cfg_force_en = 4'($urandom);
      cfg_force_val = 4'($urandom);
      cfg_invert = 4'($urandom);
      tick();
    end
    in_valid = 1'b0;
    cfg_we = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
